// File: rtl/me_mv_collector.sv
// Frame sequencer and result FIFO around the HEXBS motion-estimation core.
// Optional statistics outputs are built when ME_COLLECT_STATS_EN is defined.
module me_mv_collector #(
  parameter int MBS_X = 8,
  parameter int MBS_Y = 8,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_start,
  output logic        o_me_start,
  output logic [7:0]  o_mb_x,
  output logic [7:0]  o_mb_y,
  input  logic        i_me_done,
  input  logic [5:0]  i_mv_x,
  input  logic [5:0]  i_mv_y,
  input  logic [15:0] i_min_sad,
  output logic        o_rec_valid,
  input  logic        i_rec_ready,
  output logic [43:0] o_rec_data,
  output logic        o_frame_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [23:0] o_sad_total,
  output logic [15:0] o_zero_mv_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t         state_reg, state_next;
  logic           done_q;
  logic           hold_reg;
  logic [7:0]     mb_x_reg, mb_y_reg;
  logic           err_reg;
  logic [43:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  logic done_edge, is_last, has_space, push, pop, accept, err_set;

  assign done_edge = i_me_done & ~done_q;
  assign is_last   = (mb_x_reg == 8'(MBS_X - 1)) && (mb_y_reg == 8'(MBS_Y - 1));
  assign has_space = (count < CW'(DEPTH));
  assign pop       = o_rec_valid & i_rec_ready;

  always_comb begin
    state_next = state_reg;
    o_me_start = 1'b0;
    push       = 1'b0;
    accept     = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      IDLE: begin
        err_set = done_edge;
        if (i_frame_start) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      // hold_reg spaces consecutive starts by one idle cycle after each capture
      ISSUE: begin
        err_set = done_edge;
        if (!hold_reg && has_space) begin
          o_me_start = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (done_edge) begin
          push       = 1'b1;
          state_next = is_last ? FIN : ISSUE;
        end
      end
      FIN: begin
        err_set    = done_edge;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      done_q    <= 1'b0;
      hold_reg  <= 1'b0;
      mb_x_reg  <= '0;
      mb_y_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_q    <= i_me_done;
      hold_reg  <= (state_reg == WAIT) && (state_next == ISSUE);
      if (err_set) err_reg <= 1'b1;
      if (accept) begin
        mb_x_reg <= '0;
        mb_y_reg <= '0;
      end else if (push && !is_last) begin
        if (mb_x_reg == 8'(MBS_X - 1)) begin
          mb_x_reg <= '0;
          mb_y_reg <= mb_y_reg + 8'd1;
        end else begin
          mb_x_reg <= mb_x_reg + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {mb_y_reg, mb_x_reg, i_mv_y, i_mv_x, i_min_sad};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_rec_valid  = (count != '0);
  assign o_rec_data   = o_rec_valid ? mem[rd_ptr] : '0;
  assign o_mb_x       = mb_x_reg;
  assign o_mb_y       = mb_y_reg;
  assign o_busy       = (state_reg == ISSUE) || (state_reg == WAIT);
  assign o_frame_done = (state_reg == FIN);
  assign o_err        = err_reg;

`ifdef ME_COLLECT_STATS_EN
  logic [23:0] sad_total_reg;
  logic [15:0] zero_cnt_reg;
  logic [24:0] sad_sum;

  assign sad_sum = {1'b0, sad_total_reg} + 25'(i_min_sad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_total_reg <= '0;
      zero_cnt_reg  <= '0;
    end else if (accept) begin
      sad_total_reg <= '0;
      zero_cnt_reg  <= '0;
    end else if (push) begin
      sad_total_reg <= sad_sum[24] ? '1 : sad_sum[23:0];
      if ((i_mv_x == '0) && (i_mv_y == '0) && (zero_cnt_reg != '1))
        zero_cnt_reg <= zero_cnt_reg + 16'd1;
    end
  end

  assign o_sad_total   = sad_total_reg;
  assign o_zero_mv_cnt = zero_cnt_reg;
`else
  assign o_sad_total   = '0;
  assign o_zero_mv_cnt = '0;
`endif

endmodule
